// File: rtl/button_event_decoder.sv
// Classifies a debounced button level into ShortPress, DoubleClick and
// LongPress pulses plus a Held level. All outputs are registered.
module button_event_decoder #(
  parameter int unsigned LONG_CYCLES = 100000000,
  parameter int unsigned GAP_CYCLES  = 25000000,
  parameter int unsigned CNT_W       = 27
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Pressed,
  output logic ShortPress,
  output logic DoubleClick,
  output logic LongPress,
  output logic Held
);

  typedef enum logic [2:0] {
    DISARMED,
    IDLE,
    PRESS1,
    WAIT2,
    PRESS2,
    LONG_HELD
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_n;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_n;
  logic             r_short;
  logic             r_double;
  logic             r_long;
  logic             r_held;
  logic             w_short;
  logic             w_double;
  logic             w_long;
  logic             w_held;

  // State, counter and output registers; reset forces DISARMED and quiet outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= DISARMED;
      r_cnt    <= '0;
      r_short  <= 1'b0;
      r_double <= 1'b0;
      r_long   <= 1'b0;
      r_held   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_short  <= w_short;
      r_double <= w_double;
      r_long   <= w_long;
      r_held   <= w_held;
    end
  end

  // Next-state, counter and next-output decode for the press classifier.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_short   = 1'b0;
    w_double  = 1'b0;
    w_long    = 1'b0;
    unique case (r_state)
      DISARMED: begin
        // A button held through reset must be seen released before arming.
        if (!Pressed) w_state_n = IDLE;
      end
      IDLE: begin
        if (Pressed) begin
          w_state_n = PRESS1;
          w_cnt_n   = CNT_ONE;
        end
      end
      PRESS1: begin
        if (Pressed) begin
          if (r_cnt == LONG_LAST) begin
            w_long    = 1'b1;
            w_state_n = LONG_HELD;
          end else begin
            w_cnt_n = r_cnt + CNT_ONE;
          end
        end else begin
          w_state_n = WAIT2;
          w_cnt_n   = CNT_ONE;
        end
      end
      WAIT2: begin
        if (Pressed) begin
          w_state_n = PRESS2;
          w_cnt_n   = CNT_ONE;
        end else if (r_cnt == GAP_LAST) begin
          w_short   = 1'b1;
          w_state_n = IDLE;
        end else begin
          w_cnt_n = r_cnt + CNT_ONE;
        end
      end
      PRESS2: begin
        if (!Pressed) begin
          w_double  = 1'b1;
          w_state_n = IDLE;
        end else if (r_cnt != '1) begin
          // Saturate rather than wrap during an arbitrarily long second press.
          w_cnt_n = r_cnt + CNT_ONE;
        end
      end
      LONG_HELD: begin
        if (!Pressed) w_state_n = IDLE;
      end
      default: begin
        w_state_n = DISARMED;
      end
    endcase
    w_held = (w_state_n == LONG_HELD);
  end

  assign ShortPress  = r_short;
  assign DoubleClick = r_double;
  assign LongPress   = r_long;
  assign Held        = r_held;

endmodule
